modinv_helper_invert_update: RTL and testbench
==============================================

Name: modinv_helper_invert_update

Overview:
- Write-back counterpart of the invert precalc helper. It runs once per almost-inverse loop iteration.
- It probes u/v parity and the sign of (u - v) to pick one of four update cases.
- It then reads the selected precalculated buffers word by word and writes them into the r/s/u/v working buffers.
- It sits beside the precalc helper under the modular invertor FSM, which alternates the two helpers.

Parameters:
- BUFFER_NUM_WORDS, 9, words per operand buffer; the top word holds the sign of the differences.
- BUFFER_ADDR_BITS, 4, buffer address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- ena  in  1  start request, sampled only while rdy=1
- rdy  out  1  idle/done flag
- u_rd_addr, v_rd_addr, u_minus_v_rd_addr  out  BUFFER_ADDR_BITS  probe addresses
- u_din, v_din, u_minus_v_din  in  32  probe read data, 1-cycle RAM latency
- src_addr  out  BUFFER_ADDR_BITS  shared read address for all precalc buffers
- r_dbl_din, s_dbl_din, r_plus_s_din, u_half_din, v_half_din, u_minus_v_half_din, v_minus_u_half_din  in  32  precalc read data
- r_wr_addr, s_wr_addr, u_wr_addr, v_wr_addr  out  BUFFER_ADDR_BITS  write addresses (one shared register)
- r_wren, s_wren, u_wren, v_wren  out  1  per-buffer write enables
- r_dout, s_dout, u_dout, v_dout  out  32  write data
- upd_case  out  2  case latched for the current/last iteration
- zero_flag  out  1  halved difference written this iteration was all-zero

Behaviour:
- Clocking and reset:
  - Single clock. Reset is synchronous, active-low.
  - Reset values: state IDLE, rdy=1, all wren=0, src_addr=0, wr_addr=0, upd_case=0, zero_flag=0.
  - Probe addresses reset to u_rd_addr=v_rd_addr=0 and u_minus_v_rd_addr=N-1.
  - Reset during any state aborts the iteration immediately; no further wren pulses.
- Probe addresses are constant outputs (0, 0, N-1), so probe data is always valid one cycle after reset or any write.
- States:
  - IDLE: rdy=1. On ena go to DECIDE. ena is ignored in every other state.
  - DECIDE (1 cycle): latch upd_case by priority:
    - 0 U_EVEN if u_din[0]=0
    - else 1 V_EVEN if v_din[0]=0
    - else 2 U_GE_V if u_minus_v_din[31]=0
    - else 3 V_GT_U
  - DECIDE also clears zero_flag and the zero accumulator, sets src_addr=0, then goes to COPY.
  - COPY (N cycles): src_addr counts 0..N-1. The word read at address k is written at address k one cycle later (wr_addr = src_addr delayed by 1). After issuing N-1, go to DRAIN.
  - DRAIN (1 cycle): write word N-1, set src_addr=0, return to IDLE.
- Latency: ena cycle to rdy high again is N+2 cycles. Writes occupy exactly N consecutive cycles, starting 2 cycles after ena.
- Case mapping; buffers not listed keep wren=0:
  - 0 U_EVEN: u<=u_half, s<=s_dbl
  - 1 V_EVEN: v<=v_half, r<=r_dbl
  - 2 U_GE_V: u<=u_minus_v_half, r<=r_plus_s, s<=s_dbl
  - 3 V_GT_U: v<=v_minus_u_half, s<=r_plus_s, r<=r_dbl
- dout is a pure mux of the din ports on the latched case. There is no arithmetic in this block; the precalc helper already did the shifts and carries.
- zero_flag:
  - Case 2/3: OR-reduce every halved-difference word written. zero_flag=1 at return to IDLE iff all N words were 0. Held until the next DECIDE.
  - Case 0/1: zero_flag=0.
- u==v (both odd): sign bit 0 selects case 2, u becomes 0, zero_flag=1. The invertor FSM uses this as its termination condition.
- wr_addr never wraps within an iteration. src_addr returns to 0 in DRAIN.

Decomposition:
- Shared package / include: case codes (UPD_U_EVEN=0, UPD_V_EVEN=1, UPD_U_GE_V=2, UPD_V_GT_U=3), state encoding, and the existing clog2 include for the counter width.
- One natural sub-module: modinv_helper_update_mux. It is a combinational 4-way case-to-source selector producing the four dout and four wren signals from upd_case and a write-active strobe.

Test Plan:
1. Reset held 3 cycles, then released -> rdy=1, all wren=0, zero_flag=0, probe addresses 0/0/8.
2. u word0=0x00000004, ena pulse -> upd_case=0. u_wren and s_wren high for 9 cycles starting 2 cycles after ena; u_dout=u_half_din, s_dout=s_dbl_din at addresses 0..8; r_wren=v_wren=0; rdy back after 11 cycles.
3. u=0x...03, v=0x...08 -> upd_case=1; only v and r written, from v_half and r_dbl.
4. u=7, v=5 (u_minus_v top word 0x00000000) -> upd_case=2. u/r/s written from u_minus_v_half / r_plus_s / s_dbl; zero_flag=0 given a nonzero u_minus_v_half word0=1.
5. u=5, v=7 (u_minus_v top word 0xFFFFFFFF) -> upd_case=3; v/s/r written. Then u=v=5 with all u_minus_v_half words 0 -> upd_case=2, zero_flag=1.
6. rst_n low on the 4th COPY cycle -> next cycle all wren=0, rdy=1. ena held high during COPY -> no restart until rdy; exactly 9 writes per iteration.

Source files
------------

// File: rtl/modinv_helper_invert_update_pkg.sv
// Shared definitions for the almost-inverse update helper: update case codes,
// FSM state encoding, buffer geometry and a constant-width helper.
package modinv_helper_invert_update_pkg;

  // Ceiling log2 for sizing counters from a word count.
  function automatic int clog2_f(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < 32'(value)) begin
        width = i + 1;
      end else begin
        width = width;
      end
    end
    return width;
  endfunction

  localparam int BUF_NUM_WORDS = 9;
  localparam int BUF_ADDR_BITS = clog2_f(BUF_NUM_WORDS);

  // Update case selected from u/v parity and the sign of u - v.
  typedef enum logic [1:0] {
    UPD_U_EVEN = 2'd0,
    UPD_V_EVEN = 2'd1,
    UPD_U_GE_V = 2'd2,
    UPD_V_GT_U = 2'd3
  } upd_case_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECIDE = 2'd1,
    ST_COPY   = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

endpackage

// File: rtl/modinv_helper_invert_update_if.sv
// Precalc-buffer read bus and r/s/u/v working-buffer write bus of the
// update helper. The helper is the master; the buffer RAMs are the slave.
interface modinv_helper_invert_update_if
  import modinv_helper_invert_update_pkg::*;
#(
  parameter int ADDR_BITS = BUF_ADDR_BITS
);

  // shared read address for all precalculated buffers
  logic [ADDR_BITS-1:0] src_addr;
  logic [31:0]          r_dbl_din;
  logic [31:0]          s_dbl_din;
  logic [31:0]          r_plus_s_din;
  logic [31:0]          u_half_din;
  logic [31:0]          v_half_din;
  logic [31:0]          u_minus_v_half_din;
  logic [31:0]          v_minus_u_half_din;

  // working-buffer write ports
  logic [ADDR_BITS-1:0] r_wr_addr;
  logic [ADDR_BITS-1:0] s_wr_addr;
  logic [ADDR_BITS-1:0] u_wr_addr;
  logic [ADDR_BITS-1:0] v_wr_addr;
  logic                 r_wren;
  logic                 s_wren;
  logic                 u_wren;
  logic                 v_wren;
  logic [31:0]          r_dout;
  logic [31:0]          s_dout;
  logic [31:0]          u_dout;
  logic [31:0]          v_dout;

  modport master (
    output src_addr,
    input  r_dbl_din, s_dbl_din, r_plus_s_din, u_half_din, v_half_din,
           u_minus_v_half_din, v_minus_u_half_din,
    output r_wr_addr, s_wr_addr, u_wr_addr, v_wr_addr,
    output r_wren, s_wren, u_wren, v_wren,
    output r_dout, s_dout, u_dout, v_dout
  );

  modport slave (
    input  src_addr,
    output r_dbl_din, s_dbl_din, r_plus_s_din, u_half_din, v_half_din,
           u_minus_v_half_din, v_minus_u_half_din,
    input  r_wr_addr, s_wr_addr, u_wr_addr, v_wr_addr,
    input  r_wren, s_wren, u_wren, v_wren,
    input  r_dout, s_dout, u_dout, v_dout
  );

endinterface

// File: rtl/modinv_helper_update_mux.sv
// Case-to-source selector: routes precalculated words to the r/s/u/v write
// ports and raises the matching write enables while the copy is active.
module modinv_helper_update_mux
  import modinv_helper_invert_update_pkg::*;
(
  input  upd_case_e   upd_case,
  input  logic        wr_active,
  input  logic [31:0] r_dbl_din,
  input  logic [31:0] s_dbl_din,
  input  logic [31:0] r_plus_s_din,
  input  logic [31:0] u_half_din,
  input  logic [31:0] v_half_din,
  input  logic [31:0] u_minus_v_half_din,
  input  logic [31:0] v_minus_u_half_din,
  output logic [31:0] r_dout,
  output logic [31:0] s_dout,
  output logic [31:0] u_dout,
  output logic [31:0] v_dout,
  output logic        r_wren,
  output logic        s_wren,
  output logic        u_wren,
  output logic        v_wren
);

  // Select sources and enables; untouched buffers see zero data and no enable.
  always_comb begin
    r_dout = 32'h0000_0000;
    s_dout = 32'h0000_0000;
    u_dout = 32'h0000_0000;
    v_dout = 32'h0000_0000;
    r_wren = 1'b0;
    s_wren = 1'b0;
    u_wren = 1'b0;
    v_wren = 1'b0;
    case (upd_case)
      UPD_U_EVEN: begin
        u_dout = u_half_din;
        s_dout = s_dbl_din;
        u_wren = wr_active;
        s_wren = wr_active;
      end
      UPD_V_EVEN: begin
        v_dout = v_half_din;
        r_dout = r_dbl_din;
        v_wren = wr_active;
        r_wren = wr_active;
      end
      UPD_U_GE_V: begin
        u_dout = u_minus_v_half_din;
        r_dout = r_plus_s_din;
        s_dout = s_dbl_din;
        u_wren = wr_active;
        r_wren = wr_active;
        s_wren = wr_active;
      end
      UPD_V_GT_U: begin
        v_dout = v_minus_u_half_din;
        s_dout = r_plus_s_din;
        r_dout = r_dbl_din;
        v_wren = wr_active;
        s_wren = wr_active;
        r_wren = wr_active;
      end
      default: begin
        r_wren = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/modinv_helper_invert_update.sv
// Write-back half of the almost-inverse iteration: probes u/v parity and the
// sign of u - v, picks an update case, then copies the matching precalculated
// buffers into the r/s/u/v working buffers word by word.
module modinv_helper_invert_update
  import modinv_helper_invert_update_pkg::*;
#(
  parameter int BUFFER_NUM_WORDS = 9,
  parameter int BUFFER_ADDR_BITS = clog2_f(BUFFER_NUM_WORDS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  output logic                        rdy,
  output logic [BUFFER_ADDR_BITS-1:0] u_rd_addr,
  output logic [BUFFER_ADDR_BITS-1:0] v_rd_addr,
  output logic [BUFFER_ADDR_BITS-1:0] u_minus_v_rd_addr,
  input  logic [31:0]                 u_din,
  input  logic [31:0]                 v_din,
  input  logic [31:0]                 u_minus_v_din,
  modinv_helper_invert_update_if.master bus,
  output logic [1:0]                  upd_case,
  output logic                        zero_flag
);

  localparam logic [BUFFER_ADDR_BITS-1:0] LAST_ADDR = BUFFER_ADDR_BITS'(BUFFER_NUM_WORDS - 1);
  localparam logic [BUFFER_ADDR_BITS-1:0] ZERO_ADDR = {BUFFER_ADDR_BITS{1'b0}};

  state_e                      state_r;
  state_e                      state_nxt_s;
  logic                        rdy_r;
  logic [BUFFER_ADDR_BITS-1:0] src_addr_r;
  logic [BUFFER_ADDR_BITS-1:0] wr_addr_r;
  logic                        wr_active_r;
  upd_case_e                   upd_case_r;
  upd_case_e                   decide_case_s;
  logic                        zero_flag_r;
  logic                        zero_acc_r;
  logic                        diff_case_s;
  logic                        diff_word_nz_s;
  logic                        unused_probe_bits_s;

  // Probe words live at fixed addresses: low word of u/v, top (sign) word of u - v.
  assign u_rd_addr         = ZERO_ADDR;
  assign v_rd_addr         = ZERO_ADDR;
  assign u_minus_v_rd_addr = LAST_ADDR;

  // Only the parity bits and the sign bit matter for the decision.
  assign unused_probe_bits_s = ^{u_din[31:1], v_din[31:1], u_minus_v_din[30:0]};

  // Priority decision: even u first, then even v, then the sign of u - v.
  always_comb begin
    decide_case_s = UPD_V_GT_U;
    if (u_din[0] == 1'b0) begin
      decide_case_s = UPD_U_EVEN;
    end else if (v_din[0] == 1'b0) begin
      decide_case_s = UPD_V_EVEN;
    end else if (u_minus_v_din[31] == 1'b0) begin
      decide_case_s = UPD_U_GE_V;
    end else begin
      decide_case_s = UPD_V_GT_U;
    end
  end

  // Halved difference being written this cycle, for the termination flag.
  always_comb begin
    diff_case_s    = 1'b0;
    diff_word_nz_s = 1'b0;
    case (upd_case_r)
      UPD_U_GE_V: begin
        diff_case_s    = 1'b1;
        diff_word_nz_s = |bus.u_minus_v_half_din;
      end
      UPD_V_GT_U: begin
        diff_case_s    = 1'b1;
        diff_word_nz_s = |bus.v_minus_u_half_din;
      end
      default: begin
        diff_case_s    = 1'b0;
        diff_word_nz_s = 1'b0;
      end
    endcase
  end

  // Next-state logic; ena is honoured only in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ena) begin
          state_nxt_s = ST_DECIDE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DECIDE: state_nxt_s = ST_COPY;
      ST_COPY: begin
        if (src_addr_r == LAST_ADDR) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_COPY;
        end
      end
      ST_DRAIN: state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State register, address counters, write strobe and zero tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      rdy_r       <= 1'b1;
      src_addr_r  <= ZERO_ADDR;
      wr_addr_r   <= ZERO_ADDR;
      wr_active_r <= 1'b0;
      upd_case_r  <= UPD_U_EVEN;
      zero_flag_r <= 1'b0;
      zero_acc_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      rdy_r       <= (state_nxt_s == ST_IDLE);
      // read data for an address issued in COPY arrives one cycle later
      wr_active_r <= (state_r == ST_COPY);
      case (state_r)
        ST_DECIDE: begin
          upd_case_r  <= decide_case_s;
          zero_flag_r <= 1'b0;
          zero_acc_r  <= 1'b0;
          src_addr_r  <= ZERO_ADDR;
        end
        ST_COPY: begin
          wr_addr_r <= src_addr_r;
          if (src_addr_r != LAST_ADDR) begin
            src_addr_r <= src_addr_r + BUFFER_ADDR_BITS'(1);
          end
          if (wr_active_r) begin
            zero_acc_r <= zero_acc_r | diff_word_nz_s;
          end
        end
        ST_DRAIN: begin
          src_addr_r  <= ZERO_ADDR;
          zero_acc_r  <= zero_acc_r | diff_word_nz_s;
          zero_flag_r <= diff_case_s & ~(zero_acc_r | diff_word_nz_s);
        end
        default: begin
          src_addr_r <= src_addr_r;
        end
      endcase
    end
  end

  logic [31:0] r_dout_s, s_dout_s, u_dout_s, v_dout_s;
  logic        r_wren_s, s_wren_s, u_wren_s, v_wren_s;

  modinv_helper_update_mux u_mux (
    .upd_case           (upd_case_r),
    .wr_active          (wr_active_r),
    .r_dbl_din          (bus.r_dbl_din),
    .s_dbl_din          (bus.s_dbl_din),
    .r_plus_s_din       (bus.r_plus_s_din),
    .u_half_din         (bus.u_half_din),
    .v_half_din         (bus.v_half_din),
    .u_minus_v_half_din (bus.u_minus_v_half_din),
    .v_minus_u_half_din (bus.v_minus_u_half_din),
    .r_dout             (r_dout_s),
    .s_dout             (s_dout_s),
    .u_dout             (u_dout_s),
    .v_dout             (v_dout_s),
    .r_wren             (r_wren_s),
    .s_wren             (s_wren_s),
    .u_wren             (u_wren_s),
    .v_wren             (v_wren_s)
  );

  assign bus.src_addr  = src_addr_r;
  assign bus.r_wr_addr = wr_addr_r;
  assign bus.s_wr_addr = wr_addr_r;
  assign bus.u_wr_addr = wr_addr_r;
  assign bus.v_wr_addr = wr_addr_r;
  assign bus.r_wren    = r_wren_s;
  assign bus.s_wren    = s_wren_s;
  assign bus.u_wren    = u_wren_s;
  assign bus.v_wren    = v_wren_s;
  assign bus.r_dout    = r_dout_s;
  assign bus.s_dout    = s_dout_s;
  assign bus.u_dout    = u_dout_s;
  assign bus.v_dout    = v_dout_s;

  assign rdy       = rdy_r;
  assign upd_case  = upd_case_r;
  assign zero_flag = zero_flag_r;

endmodule

// File: tb/tb_modinv_helper_invert_update.sv
// Self-checking bench for the update helper: RAM models for probe and
// precalc buffers, capture of every write, and a case-table reference model.
module tb_modinv_helper_invert_update;
  import modinv_helper_invert_update_pkg::*;

  localparam int N  = 9;
  localparam int AB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          rdy;
  logic [AB-1:0] u_rd_addr, v_rd_addr, u_minus_v_rd_addr;
  logic [31:0]   u_din, v_din, u_minus_v_din;
  logic [1:0]    upd_case;
  logic          zero_flag;

  modinv_helper_invert_update_if #(.ADDR_BITS(AB)) bus ();

  modinv_helper_invert_update #(
    .BUFFER_NUM_WORDS (N),
    .BUFFER_ADDR_BITS (AB)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ena               (ena),
    .rdy               (rdy),
    .u_rd_addr         (u_rd_addr),
    .v_rd_addr         (v_rd_addr),
    .u_minus_v_rd_addr (u_minus_v_rd_addr),
    .u_din             (u_din),
    .v_din             (v_din),
    .u_minus_v_din     (u_minus_v_din),
    .bus               (bus),
    .upd_case          (upd_case),
    .zero_flag         (zero_flag)
  );

  always #5 clk = ~clk;

  // sources: 0 r_dbl, 1 s_dbl, 2 r_plus_s, 3 u_half, 4 v_half, 5 u_minus_v_half, 6 v_minus_u_half
  logic [31:0] pre [7][16];
  logic [31:0] u_mem [16];
  logic [31:0] v_mem [16];
  logic [31:0] umv_mem [16];

  // RAM models with one cycle of read latency
  always @(posedge clk) begin
    u_din                  <= u_mem[u_rd_addr];
    v_din                  <= v_mem[v_rd_addr];
    u_minus_v_din          <= umv_mem[u_minus_v_rd_addr];
    bus.r_dbl_din          <= pre[0][bus.src_addr];
    bus.s_dbl_din          <= pre[1][bus.src_addr];
    bus.r_plus_s_din       <= pre[2][bus.src_addr];
    bus.u_half_din         <= pre[3][bus.src_addr];
    bus.v_half_din         <= pre[4][bus.src_addr];
    bus.u_minus_v_half_din <= pre[5][bus.src_addr];
    bus.v_minus_u_half_din <= pre[6][bus.src_addr];
  end

  int vectors = 0;
  int miscompares = 0;

  // captured writes per destination: 0 r, 1 s, 2 u, 3 v
  logic [31:0] got [4][16];
  int          wcnt [4];
  int          first_j, last_j, wcycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: case from the numeric relation of u and v, then a table of
  // which source lands in which destination buffer.
  task automatic model(input logic [31:0] u, input logic [31:0] v,
                       output int c, output int src [4], output logic zf);
    if (u % 2 == 0)      c = 0;
    else if (v % 2 == 0) c = 1;
    else if (u >= v)     c = 2;
    else                 c = 3;
    case (c)
      0:       src = '{-1, 1, 3, -1};
      1:       src = '{0, -1, -1, 4};
      2:       src = '{2, 1, 5, -1};
      default: src = '{0, 2, -1, 6};
    endcase
    zf = 1'b0;
    if (c >= 2) begin
      zf = 1'b1;
      for (int k = 0; k < N; k++) begin
        if (pre[c == 2 ? 5 : 6][k] != 32'd0) zf = 1'b0;
      end
    end
  endtask

  task automatic clear_capture();
    for (int d = 0; d < 4; d++) wcnt[d] = 0;
    first_j = -1;
    last_j  = -1;
    wcycles = 0;
  endtask

  // Record writes seen in the current cycle (called at the negedge).
  task automatic sample_writes(input int j);
    logic        w [4];
    logic [31:0] dd [4];
    logic [3:0]  aa [4];
    w  = '{bus.r_wren, bus.s_wren, bus.u_wren, bus.v_wren};
    dd = '{bus.r_dout, bus.s_dout, bus.u_dout, bus.v_dout};
    aa = '{bus.r_wr_addr, bus.s_wr_addr, bus.u_wr_addr, bus.v_wr_addr};
    if (w[0] || w[1] || w[2] || w[3]) begin
      if (first_j < 0) first_j = j;
      last_j = j;
      wcycles++;
    end
    for (int d = 0; d < 4; d++) begin
      if (w[d]) begin
        chk($sformatf("wr_addr dst%0d", d), 32'(aa[d]), 32'(wcnt[d]));
        got[d][aa[d]] = dd[d];
        wcnt[d]++;
      end
    end
  endtask

  task automatic load_operands(input logic [31:0] u, input logic [31:0] v, input bit zero_diff);
    u_mem[0] = u;
    v_mem[0] = v;
    for (int k = 0; k < N; k++) begin
      umv_mem[k] = $urandom;
      for (int s = 0; s < 7; s++) pre[s][k] = $urandom;
      if (zero_diff) begin
        pre[5][k] = 32'd0;
        pre[6][k] = 32'd0;
      end
    end
    umv_mem[N-1] = (u >= v) ? 32'h0000_0000 : 32'hFFFF_FFFF;
  endtask

  task automatic run_iter(input string name, input logic [31:0] u, input logic [31:0] v,
                          input bit zero_diff, input bit hold_ena);
    int   c;
    int   src [4];
    logic zf;
    bit   done;
    @(negedge clk);
    load_operands(u, v, zero_diff);
    model(u, v, c, src, zf);
    clear_capture();
    ena = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_ena) ena = 1'b0;
    done = 1'b0;
    for (int j = 0; j < 40 && !done; j++) begin
      @(negedge clk);
      if (j == 0) chk({name, " rdy_busy"}, 32'(rdy), 32'd0);
      sample_writes(j);
      if (rdy) begin
        done = 1'b1;
        chk({name, " latency"}, 32'(j), 32'(N + 2));
      end
    end
    if (!done) chk({name, " timeout"}, 32'd0, 32'd1);
    ena = 1'b0;
    chk({name, " upd_case"}, 32'(upd_case), 32'(c));
    chk({name, " zero_flag"}, 32'(zero_flag), 32'(zf));
    chk({name, " first_write"}, 32'(first_j), 32'd2);
    chk({name, " write_cycles"}, 32'(wcycles), 32'(N));
    chk({name, " write_span"}, 32'(last_j - first_j + 1), 32'(N));
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s count dst%0d", name, d), 32'(wcnt[d]), (src[d] >= 0) ? 32'(N) : 32'd0);
      if (src[d] >= 0) begin
        for (int k = 0; k < N; k++) begin
          chk($sformatf("%s data dst%0d w%0d", name, d, k), got[d][k], pre[src[d]][k]);
        end
      end
    end
    // nothing more may happen once idle with ena low
    repeat (3) begin
      @(negedge clk);
      chk({name, " idle_wren"}, 32'({bus.r_wren, bus.s_wren, bus.u_wren, bus.v_wren}), 32'd0);
      chk({name, " idle_rdy"}, 32'(rdy), 32'd1);
    end
  endtask

  task automatic check_idle(input string name);
    chk({name, " rdy"}, 32'(rdy), 32'd1);
    chk({name, " wren"}, 32'({bus.r_wren, bus.s_wren, bus.u_wren, bus.v_wren}), 32'd0);
    chk({name, " zero_flag"}, 32'(zero_flag), 32'd0);
    chk({name, " upd_case"}, 32'(upd_case), 32'd0);
    chk({name, " src_addr"}, 32'(bus.src_addr), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    ena   = 1'b0;
    for (int k = 0; k < 16; k++) begin
      u_mem[k] = 32'd0;
      v_mem[k] = 32'd0;
      umv_mem[k] = 32'd0;
      for (int s = 0; s < 7; s++) pre[s][k] = 32'd0;
    end

    // 1: reset held three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    chk("reset wr_addr", 32'(bus.r_wr_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset");
    chk("probe u_addr", 32'(u_rd_addr), 32'd0);
    chk("probe v_addr", 32'(v_rd_addr), 32'd0);
    chk("probe umv_addr", 32'(u_minus_v_rd_addr), 32'd8);

    // 2..5: one directed iteration per update case, then u == v termination
    run_iter("u_even", 32'h0000_0004, 32'h0000_0007, 1'b0, 1'b0);
    run_iter("v_even", 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0);
    run_iter("u_ge_v", 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b0);
    run_iter("v_gt_u", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b0);
    run_iter("u_eq_v", 32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0);
    run_iter("v_gt_u_zero", 32'h0000_0003, 32'h0000_0009, 1'b1, 1'b0);

    // 6a: reset on the fourth COPY cycle aborts the iteration
    @(negedge clk);
    load_operands(32'h0000_0009, 32'h0000_0003, 1'b1);
    clear_capture();
    ena = 1'b1;
    @(posedge clk);
    #1;
    ena = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      sample_writes(j);
    end
    rst_n = 1'b0;
    chk("abort writes_before", 32'(wcycles), 32'd3);
    @(negedge clk);
    check_idle("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle("abort_after");
    end

    // 6b: ena held through an iteration does not restart it early
    run_iter("hold_ena", 32'h1234_5677, 32'h0000_0010, 1'b0, 1'b1);

    // randomized iterations
    for (int i = 0; i < 12; i++) begin
      logic [31:0] ru, rv;
      ru = $urandom;
      rv = $urandom;
      if (i % 3 == 0) begin
        ru[0] = 1'b1;
        rv[0] = 1'b1;
      end
      run_iter($sformatf("rand%0d", i), ru, rv, ($urandom_range(0, 3) == 0), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
